// File: rtl/qmv_pkg.sv
// rtl/qmv_pkg.sv - shared state type, default parameters and arithmetic helpers for qmv_engine
package qmv_pkg;

   localparam int QMV_N_LEN      = 8;
   localparam int QMV_N_CH       = 4;
   localparam int QMV_X_W        = 32;
   localparam int QMV_W_W        = 8;
   localparam int QMV_ACC_W      = 48;
   localparam int QMV_SCALE_W    = 16;
   localparam int QMV_SCALE_FRAC = 8;

   // Widest packed weight word lane_extract can address
   localparam int QMV_WORD_MAX   = 1024;
   localparam int QMV_WORD_AW    = 10;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_SCALE = 3'd2,
      ST_OUT   = 3'd3,
      ST_DONE  = 3'd4
   } qmv_state_e;

   function automatic logic signed [127:0] sat_signed(input logic signed [127:0] value,
                                                      input int width);
      logic signed [127:0] hi;
      logic signed [127:0] lo;
      hi = (128'sd1 <<< (width - 1)) - 128'sd1;
      lo = -hi - 128'sd1;
      if (value > hi) return hi;
      if (value < lo) return lo;
      return value;
   endfunction

   // Sign-extended lane k of a packed word of w-bit lanes
   function automatic logic signed [31:0] lane_extract(input logic [QMV_WORD_MAX-1:0] word,
                                                       input int k,
                                                       input int w = QMV_W_W);
      logic signed [31:0] r;
      for (int i = 0; i < 32; i++) begin
         r[i] = (i < w) ? word[QMV_WORD_AW'(w * k + i)] : word[QMV_WORD_AW'(w * k + w - 1)];
      end
      return r;
   endfunction

endpackage

// File: rtl/qmv_requant.sv
// rtl/qmv_requant.sv - one-channel multiply, round-half-up shift and saturate
// Optional fused ReLU when QMV_RELU_EN is defined.
module qmv_requant
   import qmv_pkg::*;
#(
   parameter int X_W        = QMV_X_W,
   parameter int ACC_W      = QMV_ACC_W,
   parameter int SCALE_W    = QMV_SCALE_W,
   parameter int SCALE_FRAC = QMV_SCALE_FRAC
) (
   input  logic signed [ACC_W-1:0] acc_i,
   input  logic [SCALE_W-1:0]      scale_i,
   output logic [X_W-1:0]          res_o
);

   localparam int M_W = ACC_W + SCALE_W + 1;
   localparam logic [M_W-1:0] ONE = M_W'(1);
   localparam logic signed [M_W-1:0] RND = signed'((ONE << SCALE_FRAC) >> 1);

   logic signed [M_W-1:0] prod;
   logic signed [M_W-1:0] shifted;
   logic [X_W-1:0]        res;

   always_comb begin
      prod    = M_W'(acc_i) * M_W'(signed'({1'b0, scale_i}));
      shifted = (prod + RND) >>> SCALE_FRAC;
      res     = X_W'(sat_signed(128'(shifted), X_W));
`ifdef QMV_RELU_EN
      if (res[X_W-1]) res = '0;
`else
      res = res;
`endif
      res_o = res;
   end

endmodule

// File: rtl/qmv_engine.sv
// rtl/qmv_engine.sv - quantized matrix-vector engine: N_LEN beats into N_CH accumulators,
// requantized and streamed out one channel at a time (ReLU option: QMV_RELU_EN).
module qmv_engine
   import qmv_pkg::*;
#(
   parameter int N_LEN      = QMV_N_LEN,
   parameter int N_CH       = QMV_N_CH,
   parameter int X_W        = QMV_X_W,
   parameter int W_W        = QMV_W_W,
   parameter int ACC_W      = QMV_ACC_W,
   parameter int SCALE_W    = QMV_SCALE_W,
   parameter int SCALE_FRAC = QMV_SCALE_FRAC,
   localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  start_i,
   input  logic [SCALE_W-1:0]    scale_i,
   input  logic                  in_valid_i,
   input  logic [X_W-1:0]        vector_x_i,
   input  logic [N_CH*W_W-1:0]   quant_w_i,
   output logic                  busy_o,
   output logic                  dout_valid_o,
   input  logic                  dout_ready_i,
   output logic [X_W-1:0]        dout_o,
   output logic [CH_W-1:0]       dout_ch_o,
   output logic                  done_o
);

   localparam int CNT_W = $clog2(N_LEN + 1);
   localparam int P_W   = X_W + W_W;

   qmv_state_e               state_q, state_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [CH_W-1:0]          ch_q, ch_d;
   logic [SCALE_W-1:0]       scale_q, scale_d;
   logic [X_W-1:0]           dout_q, dout_d;
   logic                     dvalid_q, dvalid_d;
   logic signed [ACC_W-1:0]  acc_q [N_CH];
   logic signed [ACC_W-1:0]  acc_d [N_CH];
   logic signed [P_W-1:0]    prod [N_CH];
   logic [QMV_WORD_MAX-1:0]  w_word;
   logic [X_W-1:0]           req_res;

   assign w_word = QMV_WORD_MAX'(quant_w_i);

   always_comb begin
      for (int k = 0; k < N_CH; k++) begin
         prod[k] = P_W'(signed'(vector_x_i)) * P_W'(lane_extract(w_word, k, W_W));
      end
   end

   // Single requant datapath shared across channels, selected by ch_q
   qmv_requant #(
      .X_W       (X_W),
      .ACC_W     (ACC_W),
      .SCALE_W   (SCALE_W),
      .SCALE_FRAC(SCALE_FRAC)
   ) u_requant (
      .acc_i  (acc_q[ch_q]),
      .scale_i(scale_q),
      .res_o  (req_res)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ch_d     = ch_q;
      scale_d  = scale_q;
      dout_d   = dout_q;
      dvalid_d = dvalid_q;
      acc_d    = acc_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               scale_d = scale_i;
               cnt_d   = '0;
               ch_d    = '0;
               for (int k = 0; k < N_CH; k++) acc_d[k] = '0;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (in_valid_i) begin
               for (int k = 0; k < N_CH; k++) acc_d[k] = acc_q[k] + ACC_W'(prod[k]);
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(N_LEN - 1)) begin
                  ch_d    = '0;
                  state_d = ST_SCALE;
               end
            end
         end
         ST_SCALE: begin
            dout_d   = req_res;
            dvalid_d = 1'b1;
            state_d  = ST_OUT;
         end
         ST_OUT: begin
            if (dout_ready_i) begin
               dvalid_d = 1'b0;
               if (ch_q == CH_W'(N_CH - 1)) begin
                  state_d = ST_DONE;
               end else begin
                  ch_d    = ch_q + 1'b1;
                  state_d = ST_SCALE;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         ch_q     <= '0;
         scale_q  <= '0;
         dout_q   <= '0;
         dvalid_q <= 1'b0;
         for (int k = 0; k < N_CH; k++) acc_q[k] <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ch_q     <= ch_d;
         scale_q  <= scale_d;
         dout_q   <= dout_d;
         dvalid_q <= dvalid_d;
         acc_q    <= acc_d;
      end
   end

   assign busy_o       = (state_q != ST_IDLE);
   assign dout_valid_o = dvalid_q;
   assign dout_o       = dout_q;
   assign dout_ch_o    = ch_q;
   assign done_o       = (state_q == ST_DONE);

endmodule

// File: doc/qmv_engine.md
Name: qmv_engine

Overview:
- Parametrised quantized matrix-vector engine: streams N_LEN signed Q16.16 activations, each paired with a packed beat of N_CH signed int8 weights.
- Accumulates N_CH dot products, then applies a per-tensor requant scale with rounding and saturation.
- Streams the N_CH Q16.16 results out over a valid/ready handshake.
- Successor to the fixed 8x4 top-level matmul: adds variable dimensions, input valid gating, output backpressure and requantization.

Parameters:
- N_LEN, 8, vector length (input beats per run), >=1
- N_CH, 4, output channels (int8 weight lanes per beat), >=1
- X_W, 32, activation/result width, signed Q(X_W-16).16
- W_W, 8, weight lane width, signed
- ACC_W, 48, accumulator width, signed; must be >= X_W+W_W+clog2(N_LEN)
- SCALE_W, 16, requant scale width, unsigned
- SCALE_FRAC, 8, fractional bits of scale (0x0100 = 1.0)

Ports:
- clk_i, input, 1, clock, rising edge
- rstn_i, input, 1, synchronous active-low reset
- start_i, input, 1, begin a run; accepted only in IDLE
- scale_i, input, SCALE_W, requant scale; latched when start is accepted
- in_valid_i, input, 1, activation/weight beat valid
- vector_x_i, input, X_W, activation, signed Q16.16
- quant_w_i, input, N_CH*W_W, weights; lane k at bits [W_W*k +: W_W]
- busy_o, output, 1, high in any state other than IDLE
- dout_valid_o, output, 1, result valid
- dout_ready_i, input, 1, consumer ready
- dout_o, output, X_W, result, signed Q16.16
- dout_ch_o, output, clog2(N_CH) (min 1), channel index of dout_o
- done_o, output, 1, one-cycle pulse after the last channel handshake

Behaviour:
- Reset: synchronous, active-low on clk_i; the clock and reset are the only timing sources. Reset clears the FSM to IDLE, zeroes all accumulators, the beat counter and the channel counter, and drives busy_o=0, dout_valid_o=0, dout_o=0, dout_ch_o=0, done_o=0.
- Reset mid-run aborts immediately, with no done_o and no partial output.
- FSM states: IDLE, LOAD, SCALE, OUT, DONE.
- IDLE:
  - start_i=1: latch scale_i, clear accumulators and counters, go to LOAD.
  - in_valid_i is ignored in IDLE, including in the start cycle.
- LOAD:
  - Each cycle with in_valid_i=1: acc[k] += sext(vector_x_i) * sext(w_k) for all k; beat count increments.
  - Gaps (in_valid_i=0) are allowed and do not advance the count.
  - On the N_LEN-th accepted beat, go to SCALE with ch=0.
  - start_i is ignored in every non-IDLE state.
- SCALE (1 cycle):
  - r = (acc[ch]*scale + 2^(SCALE_FRAC-1)) >>> SCALE_FRAC, arithmetic shift, i.e. round half toward +inf.
  - Saturate r to signed X_W range.
  - Register into dout_o, set dout_ch_o=ch, set dout_valid_o=1, go to OUT.
- OUT:
  - dout_o, dout_ch_o and dout_valid_o are held stable until dout_valid_o && dout_ready_i.
  - On handshake: dout_valid_o=0. If ch==N_CH-1 go to DONE; otherwise ch++ and go to SCALE.
- DONE: done_o=1 for one cycle, then go to IDLE.
- Latency:
  - First dout_valid_o is asserted 2 cycles after the clock edge accepting the last beat.
  - Each following channel needs at least 2 cycles per result; the bubble is fixed.
  - done_o is asserted the cycle after the final handshake.
- Arithmetic:
  - Product is X_W+W_W bits, sign-extended to ACC_W.
  - No accumulator saturation; the ACC_W sizing rule guarantees no overflow.
  - The scale multiply is done at ACC_W+SCALE_W+1 bits.
- Zero scale yields 0 on every channel.
- dout_ready_i held high gives back-to-back channels at the 2-cycle cadence.

Optional Feature:
- Macro: QMV_RELU_EN.
- Defined: after saturation, negative r is replaced by 0 before it is registered (fused ReLU).
- Undefined: signed results pass unchanged.
- Port list is identical in both builds.

Decomposition:
- Package qmv_pkg holds:
  - FSM state enum type (IDLE, LOAD, SCALE, OUT, DONE) and its encoding;
  - default parameter constants;
  - functions sat_signed(value, width) and lane_extract(word, k).
- Sub-module qmv_requant: combinational multiply-round-shift-saturate (plus optional ReLU) for one channel, instantiated once and time-multiplexed by ch.

Test Plan:
- Basic run (defaults), scale=0x0100, 8 beats x=0x00010000 (1.0), all lanes w=1, dout_ready_i=1 -> ch0..3 each dout_o=0x00080000 (8.0), dout_ch_o=0,1,2,3 in order, done_o single pulse.
- Sign and rounding, scale=0x0080 (0.5):
  - Beat0 x=0xFFFEB000 (-1.3125), lane0 w=-128, other lanes 0; remaining 7 beats x=0 -> ch0=0x00540000 (84.0), ch1..3=0.
  - Lane0 w=1, scale=0x0080, x=0x00000001 once -> 1*0.5 rounds up to 0x00000001.
- Saturation and ReLU:
  - 8 beats x=0x7FFFFFFF, w=127 -> every channel 0x7FFFFFFF.
  - 8 beats x=1.0, w=-1 -> 0xFFF80000 (-8.0) without QMV_RELU_EN, 0x00000000 with it.
- Backpressure: basic run with dout_ready_i held low 5 cycles on ch1 -> dout_o/dout_ch_o stable, no skipped or duplicated channel, done_o only after the ch3 handshake.
- Gaps and ignores:
  - in_valid_i toggled every other cycle -> same results as the basic run.
  - start_i pulsed during LOAD and OUT -> no effect.
  - in_valid_i in IDLE -> not accumulated.
- Reset mid-run: rstn_i low for 1 cycle after 3 LOAD beats -> all outputs at reset values, busy_o=0; a fresh basic run afterwards gives 0x00080000 on all channels.
